mantissa_product_normalizer: RTL and testbench

MANTISSA_PRODUCT_NORMALIZER -- requirements
Module: mantissa_product_normalizer

---
 rtl/posit_fmau_pkg.sv | 19 +
 rtl/mant_lane_norm.sv | 24 ++
 rtl/mantissa_product_normalizer.sv | 92 +++++++++
 tb/tb_mantissa_product_normalizer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_fmau_pkg.sv
// posit_fmau_pkg: lane-mode encodings, lane widths and lane counts for the mantissa datapath
// No ports; imported by mant_lane_norm and mantissa_product_normalizer.
package posit_fmau_pkg;
    typedef enum logic [1:0] {
        OP_1X28 = 2'b00,
        OP_2X14 = 2'b01,
        OP_4X7  = 2'b10,
        OP_RSVD = 2'b11
    } lane_op_e;
    localparam int PROD_W    = 56;
    localparam int FRAC_W    = 28;
    localparam int MAX_LANES = 4;
    localparam int LANE_W28  = 28;
    localparam int LANE_W14  = 14;
    localparam int LANE_W7   = 7;
    function automatic int lane_count(input lane_op_e op);
        return op == OP_1X28 ? 1 : op == OP_2X14 ? 2 : op == OP_4X7 ? 4 : 0;
    endfunction
endpackage

// File: rtl/mant_lane_norm.sv
// mant_lane_norm: one-bit normalization of a single 2W-bit lane mantissa product
// Ports: p (2W-bit product) -> frac ({W-1 fraction, guard}), exp_inc, sticky, zero.
// Macro MANT_NORM_STICKY_EN builds the sticky OR; otherwise sticky is tied to 0.
module mant_lane_norm #(
    parameter int W = 28
) (
    input  logic [2*W-1:0] p,
    output logic [W-1:0]   frac,
    output logic           exp_inc,
    output logic           sticky,
    output logic           zero
);
    // Slicing p directly at two offsets avoids building the shifted product.
    always_comb begin
        exp_inc = p[2*W-1];
        frac    = exp_inc ? p[2*W-2:W-1] : p[2*W-3:W-2];
        zero    = ~|p;
`ifdef MANT_NORM_STICKY_EN
        sticky  = exp_inc ? |p[W-2:0] : |p[W-3:0];
`else
        sticky  = 1'b0;
`endif
    end
endmodule

// File: rtl/mantissa_product_normalizer.sv
// mantissa_product_normalizer: 2-stage valid/ready normalizer for 1x28, 2x14 or 4x7 SIMD mantissa products
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready with prod[55:0], op[1:0];
//        out_valid/out_ready with frac_out[27:0], exp_inc[3:0], sticky[3:0], lane_zero[3:0], op_err.
// Macro MANT_NORM_STICKY_EN enables the per-lane sticky outputs (constant 0 otherwise).
module mantissa_product_normalizer
    import posit_fmau_pkg::*;
#(
    parameter int LAT_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PROD_W-1:0]    prod,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAC_W-1:0]    frac_out,
    output logic [MAX_LANES-1:0] exp_inc,
    output logic [MAX_LANES-1:0] sticky,
    output logic [MAX_LANES-1:0] lane_zero,
    output logic                 op_err
);
    logic [LAT_STAGES-1:0]  vld;
    logic [PROD_W-1:0]      prod_s1;
    lane_op_e               op_s1;
    logic                   adv_s2;
    logic [FRAC_W-1:0]      f28;
    logic                   e28, s28, z28;
    logic [1:0][13:0]       f14;
    logic [1:0]             e14, s14, z14;
    logic [3:0][6:0]        f7;
    logic [3:0]             e7, s7, z7;
    logic [FRAC_W-1:0]      frac_n;
    logic [MAX_LANES-1:0]   inc_n, stk_n, zero_n;
    logic                   err_n;

    mant_lane_norm #(.W(LANE_W28)) u_l28 (
        .p(prod_s1), .frac(f28), .exp_inc(e28), .sticky(s28), .zero(z28)
    );
    for (genvar k = 0; k < 2; k++) begin : g_l14
        mant_lane_norm #(.W(LANE_W14)) u_lane (
            .p(prod_s1[28*k +: 28]), .frac(f14[k]), .exp_inc(e14[k]), .sticky(s14[k]), .zero(z14[k])
        );
    end
    for (genvar k = 0; k < 4; k++) begin : g_l7
        mant_lane_norm #(.W(LANE_W7)) u_lane (
            .p(prod_s1[14*k +: 14]), .frac(f7[k]), .exp_inc(e7[k]), .sticky(s7[k]), .zero(z7[k])
        );
    end

    // Every lane width is computed in parallel; op only selects which set reaches stage 2.
    always_comb begin
        frac_n = op_s1 == OP_1X28 ? f28 : op_s1 == OP_2X14 ? f14 : op_s1 == OP_4X7 ? f7 : '0;
        inc_n  = op_s1 == OP_1X28 ? {3'b0, e28} : op_s1 == OP_2X14 ? {2'b0, e14} : op_s1 == OP_4X7 ? e7 : '0;
        stk_n  = op_s1 == OP_1X28 ? {3'b0, s28} : op_s1 == OP_2X14 ? {2'b0, s14} : op_s1 == OP_4X7 ? s7 : '0;
        zero_n = op_s1 == OP_1X28 ? {3'b0, z28} : op_s1 == OP_2X14 ? {2'b0, z14} : op_s1 == OP_4X7 ? z7 : '0;
        err_n  = op_s1 == OP_RSVD;
    end

    // Stage 2 moves when empty or drained; stage 1 moves whenever stage 2 can take its beat.
    assign adv_s2    = !vld[LAT_STAGES-1] || out_ready;
    assign in_ready  = !vld[0] || adv_s2;
    assign out_valid = vld[LAT_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld       <= '0;
            prod_s1   <= '0;
            op_s1     <= OP_1X28;
            frac_out  <= '0;
            exp_inc   <= '0;
            sticky    <= '0;
            lane_zero <= '0;
            op_err    <= 1'b0;
        end else begin
            if (in_ready) vld[0] <= in_valid;
            if (in_ready && in_valid) begin
                prod_s1 <= prod;
                op_s1   <= lane_op_e'(op);
            end
            if (adv_s2) vld[LAT_STAGES-1] <= vld[0];
            if (adv_s2 && vld[0]) begin
                frac_out  <= frac_n;
                exp_inc   <= inc_n;
                sticky    <= stk_n;
                lane_zero <= zero_n;
                op_err    <= err_n;
            end
        end
    end
endmodule

// File: tb/tb_mantissa_product_normalizer.sv
// tb_mantissa_product_normalizer: scoreboard bench for mantissa_product_normalizer
// No ports; honours MANT_NORM_STICKY_EN in its reference model.
module tb_mantissa_product_normalizer;
    typedef struct packed {
        logic        err;
        logic [3:0]  zero;
        logic [3:0]  stk;
        logic [3:0]  inc;
        logic [27:0] frac;
    } res_t;

`ifdef MANT_NORM_STICKY_EN
    localparam logic [3:0] STK_LSB = 4'b0001;
`else
    localparam logic [3:0] STK_LSB = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [55:0] prod = '0;
    logic [1:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [27:0] frac_out;
    logic [3:0]  exp_inc, sticky, lane_zero;
    logic        op_err;
    res_t        got;
    res_t        held;
    res_t        q[$];
    bit          stalled = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_out = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mantissa_product_normalizer #(.LAT_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .prod(prod), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .frac_out(frac_out), .exp_inc(exp_inc), .sticky(sticky),
        .lane_zero(lane_zero), .op_err(op_err)
    );

    assign got = {op_err, lane_zero, sticky, exp_inc, frac_out};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic res_t model(input logic [55:0] p, input logic [1:0] o);
        res_t        r;
        int          w;
        logic [63:0] lp, pn;
        r = '0;
        if (o == 2'b11) begin
            r.err = 1'b1;
            return r;
        end
        w = o == 2'b00 ? 28 : o == 2'b01 ? 14 : 7;
        for (int k = 0; k < 28 / w; k++) begin
            lp = (64'(p) >> (2 * w * k)) & ((64'd1 << (2 * w)) - 64'd1);
            pn = lp[2*w-1] ? lp : lp << 1;
            r.zero[k] = lp == 64'd0;
            r.inc[k]  = lp[2*w-1];
            r.frac    = r.frac | (28'((pn >> (w - 1)) & ((64'd1 << w) - 64'd1)) << (w * k));
`ifdef MANT_NORM_STICKY_EN
            r.stk[k]  = |(pn & ((64'd1 << (w - 1)) - 64'd1));
`endif
        end
        return r;
    endfunction

    // Scoreboard: push on accept, pop on emit, hold check while stalled.
    always @(negedge clk) begin : monitor
        if (!rst_n) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(got), 64'(held));
            end
            if (in_valid && in_ready) q.push_back(model(prod, op));
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) check("spurious_beat", 64'(out_valid), 64'd0);
                else check("beat", 64'(got), 64'(q.pop_front()));
            end
            stalled = out_valid && !out_ready;
            held = got;
        end
    end

    task automatic send(input logic [55:0] p, input logic [1:0] o, input bit rdy);
        bit acc;
        int t;
        prod = p;
        op = o;
        in_valid = 1'b1;
        out_ready = rdy;
        t = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) out_ready = 1'b1;
            t++;
        end while (!acc && t < 20);
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic one(input logic [55:0] p, input logic [1:0] o);
        int t;
        t = 0;
        send(p, o, 1'b1);
        while (!out_valid && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("one_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          lat, n0, c0;
        logic [63:0] r;
        logic [55:0] pb[4];
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", 64'(got), 64'd0);
        rst_n = 1'b1;

        prod = 56'h80_0000_0000_0000;
        op = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        check("p035_exp_inc", 64'(exp_inc), 64'h1);
        check("p035_frac", 64'(frac_out), 64'd0);
        check("p035_sticky", 64'(sticky), 64'd0);
        check("p035_lane_zero", 64'(lane_zero), 64'd0);
        drain();

        one(56'h40_0000_0000_0001, 2'b00);
        check("p036_exp_inc", 64'(exp_inc), 64'd0);
        check("p036_frac", 64'(frac_out), 64'd0);
        check("p036_sticky", 64'(sticky), 64'(STK_LSB));
        one({4{14'h1000}}, 2'b10);
        check("p037_exp_inc", 64'(exp_inc), 64'd0);
        check("p037_frac", 64'(frac_out), 64'd0);
        check("p037_sticky", 64'(sticky), 64'd0);
        check("p037_lane_zero", 64'(lane_zero), 64'd0);
        one({14'h1000, 14'h1000, 14'h0000, 14'h1000}, 2'b10);
        check("p037_one_zero", 64'(lane_zero), 64'h2);
        one(56'hA5_5A5A_1234_5678, 2'b11);
        check("p038_op_err", 64'(op_err), 64'd1);
        check("p038_rest", 64'({lane_zero, sticky, exp_inc, frac_out}), 64'd0);
        one({28'h800_0000, 28'h400_0001}, 2'b01);
        check("w14_exp_inc", 64'(exp_inc), 64'h2);
        drain();

        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            r = {$urandom, $urandom};
            send(r[55:0], 2'(i % 3), 1'b1);
        end
        check("throughput", 64'(cyc - c0), 64'd8);
        drain();

        for (int i = 0; i < 60; i++) begin
            r = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r[13:0] = '0;
            if ($urandom_range(0, 3) == 0) r[41:28] = '0;
            if ($urandom_range(0, 5) == 0) r = '0;
            send(r[55:0], 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
        end
        drain();

        for (int i = 0; i < 4; i++) begin
            r = {$urandom, $urandom};
            pb[i] = r[55:0];
        end
        n0 = n_out;
        out_ready = 1'b0;
        op = 2'b00;
        prod = pb[0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        prod = pb[1];
        @(posedge clk);
        #1;
        prod = pb[2];
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_accepted", 64'(q.size()), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        check("bp_still_full", 64'(in_ready), 64'd0);
        send(pb[2], 2'b00, 1'b1);
        send(pb[3], 2'b00, 1'b1);
        drain();
        check("bp_emitted", 64'(n_out - n0), 64'd4);

        r = {$urandom, $urandom};
        send(r[55:0], 2'b00, 1'b1);
        r = {$urandom, $urandom};
        send(r[55:0], 2'b01, 1'b1);
        rst_n = 1'b0;
        n0 = n_out;
        @(posedge clk);
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_outputs", 64'(got), 64'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_stale", 64'(n_out - n0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
